// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and operand
// forwarding. It captures the decoded instruction once per cycle and feeds
// the ALU with operands forwarded from the MEM and WB stages.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 5,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [RA_W-1:0]   id_rs1,
  input  logic [RA_W-1:0]   id_rs2,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic              id_use_imm,
  input  logic [CTRL_W-1:0] id_alu_ctrl,
  input  logic [XLEN-1:0]   id_pc,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_is_branch,
  input  logic [RA_W-1:0]   exmem_rd,
  input  logic              exmem_reg_write,
  input  logic [XLEN-1:0]   exmem_result,
  input  logic [RA_W-1:0]   memwb_rd,
  input  logic              memwb_reg_write,
  input  logic [XLEN-1:0]   memwb_result,
  input  logic              stall,
  input  logic              flush,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_in1,
  output logic [XLEN-1:0]   ex_in2,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [XLEN-1:0]   ex_pc,
  output logic [RA_W-1:0]   ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_is_branch
);

  // EX-stage copies of the source addresses and operand data
  logic [RA_W-1:0] rs1_p1;
  logic [RA_W-1:0] rs2_p1;
  logic [XLEN-1:0] rs1_data_p1;
  logic [XLEN-1:0] rs2_data_p1;
  logic [XLEN-1:0] imm_p1;
  logic            use_imm_p1;

  logic [XLEN-1:0] cap_rs1;
  logic [XLEN-1:0] cap_rs2;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic            bubble;

  // Regfile write-then-read: a value retiring in WB this cycle is not yet
  // visible in the regfile read data, so take it straight from WB.
  function automatic logic [XLEN-1:0] wb_bypass(input logic [RA_W-1:0] rs,
                                                input logic [XLEN-1:0] rdata);
    if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs))
      return memwb_result;
    return rdata;
  endfunction

  // Youngest producer wins; x0 is hardwired zero and never forwarded.
  function automatic logic [XLEN-1:0] fwd_operand(input logic [RA_W-1:0] rs,
                                                  input logic [XLEN-1:0] cap);
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs))
      return exmem_result;
    if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs))
      return memwb_result;
    return cap;
  endfunction

  // Load-use detection: rs2 matters only when the ALU reads it or a store
  // needs it as data; rs1 is always consumed.
  always_comb begin
    hazard_stall = id_valid && ex_valid && ex_mem_read && (ex_rd != '0) &&
                   ((ex_rd == id_rs1) ||
                    ((ex_rd == id_rs2) && (!id_use_imm || id_mem_write)));
    bubble  = rst || flush || (!stall && (hazard_stall || !id_valid));
    cap_rs1 = wb_bypass(id_rs1, id_rs1_data);
    cap_rs2 = wb_bypass(id_rs2, id_rs2_data);
  end

  // ID -> EX register: reset/flush/hazard insert a bubble, stall holds
  always_ff @(posedge clk) begin
    if (bubble) begin
      ex_valid     <= 1'b0;
      ex_ctrl      <= '0;
      ex_pc        <= '0;
      ex_rd        <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_is_branch <= 1'b0;
      rs1_p1       <= '0;
      rs2_p1       <= '0;
      rs1_data_p1  <= '0;
      rs2_data_p1  <= '0;
      imm_p1       <= '0;
      use_imm_p1   <= 1'b0;
    end else if (!stall) begin
      ex_valid     <= 1'b1;
      ex_ctrl      <= id_alu_ctrl;
      ex_pc        <= id_pc;
      ex_rd        <= id_rd;
      ex_reg_write <= id_reg_write;
      ex_mem_read  <= id_mem_read;
      ex_mem_write <= id_mem_write;
      ex_is_branch <= id_is_branch;
      rs1_p1       <= id_rs1;
      rs2_p1       <= id_rs2;
      rs1_data_p1  <= cap_rs1;
      rs2_data_p1  <= cap_rs2;
      imm_p1       <= id_imm;
      use_imm_p1   <= id_use_imm;
    end
  end

  // EX stage: zero-cycle forwarding onto the ALU operand buses
  always_comb begin
    fwd_rs1       = fwd_operand(rs1_p1, rs1_data_p1);
    fwd_rs2       = fwd_operand(rs2_p1, rs2_data_p1);
    ex_in1        = fwd_rs1;
    ex_in2        = use_imm_p1 ? imm_p1 : fwd_rs2;
    ex_store_data = fwd_rs2;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios followed by randomized traffic,
// all checked against an instruction-level model of the EX slot.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic        id_use_imm;
  logic [3:0]  id_alu_ctrl;
  logic        id_reg_write, id_mem_read, id_mem_write, id_is_branch;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_reg_write, memwb_reg_write;
  logic [31:0] exmem_result, memwb_result;
  logic        stall, flush;
  logic        hazard_stall, ex_valid;
  logic [31:0] ex_in1, ex_in2, ex_store_data, ex_pc;
  logic [3:0]  ex_ctrl;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch;

  int n_cmp = 0;
  int n_err = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_ctrl(id_alu_ctrl),
    .id_pc(id_pc), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_is_branch(id_is_branch),
    .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
    .exmem_result(exmem_result), .memwb_rd(memwb_rd),
    .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
    .stall(stall), .flush(flush), .hazard_stall(hazard_stall),
    .ex_valid(ex_valid), .ex_in1(ex_in1), .ex_in2(ex_in2),
    .ex_store_data(ex_store_data), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_is_branch(ex_is_branch)
  );

  always #5 clk = ~clk;

  // Contents of the EX slot as an instruction record
  typedef struct {
    logic        v;
    logic [3:0]  ctrl;
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] d1, d2, imm;
    logic        ui, rw, mr, mw, br;
  } slot_t;

  slot_t m;

  function automatic slot_t empty_slot();
    slot_t s;
    s.v = 0; s.ctrl = 0; s.pc = 0; s.rd = 0; s.rs1 = 0; s.rs2 = 0;
    s.d1 = 0; s.d2 = 0; s.imm = 0; s.ui = 0; s.rw = 0; s.mr = 0; s.mw = 0; s.br = 0;
    return s;
  endfunction

  // Value of register r as seen now by the instruction in EX
  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] regfile_val);
    if (r == 0) return regfile_val;
    if (exmem_reg_write && exmem_rd == r) return exmem_result;
    if (memwb_reg_write && memwb_rd == r) return memwb_result;
    return regfile_val;
  endfunction

  // A load in EX whose result the decoding instruction needs next cycle
  function automatic logic load_use();
    logic needs1, needs2;
    needs1 = (id_rs1 == m.rd);
    needs2 = (id_rs2 == m.rd) && (!id_use_imm || id_mem_write);
    return id_valid && m.v && m.mr && (m.rd != 0) && (needs1 || needs2);
  endfunction

  function automatic logic [31:0] wb_read(input logic [4:0] r, input logic [31:0] rf);
    return (memwb_reg_write && r != 0 && memwb_rd == r) ? memwb_result : rf;
  endfunction

  function automatic slot_t next_slot();
    slot_t s;
    if (rst || flush) return empty_slot();
    if (stall) return m;
    if (load_use() || !id_valid) return empty_slot();
    s.v = 1; s.ctrl = id_alu_ctrl; s.pc = id_pc; s.rd = id_rd;
    s.rs1 = id_rs1; s.rs2 = id_rs2; s.imm = id_imm; s.ui = id_use_imm;
    s.d1 = wb_read(id_rs1, id_rs1_data); s.d2 = wb_read(id_rs2, id_rs2_data);
    s.rw = id_reg_write; s.mr = id_mem_read; s.mw = id_mem_write; s.br = id_is_branch;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("hazard_stall", 32'(hazard_stall), 32'(load_use()));
    chk("ex_valid", 32'(ex_valid), 32'(m.v));
    chk("ex_ctrl", 32'(ex_ctrl), 32'(m.ctrl));
    chk("ex_pc", ex_pc, m.pc);
    chk("ex_rd", 32'(ex_rd), 32'(m.rd));
    chk("ex_ctl_bits", {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch},
        {28'd0, m.rw, m.mr, m.mw, m.br});
    chk("ex_in1", ex_in1, operand(m.rs1, m.d1));
    chk("ex_in2", ex_in2, m.ui ? m.imm : operand(m.rs2, m.d2));
    chk("ex_store_data", ex_store_data, operand(m.rs2, m.d2));
  endtask

  // Inputs are set at the falling edge; outputs checked 1 ns later, then one clock
  task automatic step(input bit do_check);
    #1;
    if (do_check) check_all();
    @(posedge clk);
    m = next_slot();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 0; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_use_imm = 0;
    id_alu_ctrl = 0; id_pc = 0; id_reg_write = 0; id_mem_read = 0;
    id_mem_write = 0; id_is_branch = 0; exmem_rd = 0; exmem_reg_write = 0;
    exmem_result = 0; memwb_rd = 0; memwb_reg_write = 0; memwb_result = 0;
    stall = 0; flush = 0;
  endtask

  task automatic set_alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] d1, input logic [31:0] d2);
    id_valid = 1; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_rs1_data = d1; id_rs2_data = d2; id_use_imm = 0; id_imm = 0;
    id_reg_write = 1; id_mem_read = 0; id_mem_write = 0; id_is_branch = 0;
    id_alu_ctrl = 4'h0; id_pc = id_pc + 1;
  endtask

  initial begin
    m = empty_slot();
    idle_inputs();
    @(negedge clk);

    // Reset held two cycles with a valid instruction in ID
    rst = 1; set_alu(5'd1, 5'd2, 5'd3, 32'h11, 32'h22); id_is_branch = 1;
    step(0);
    m = empty_slot();
    step(1);
    #1 chk("reset_ex_valid", 32'(ex_valid), 32'd0);
    chk("reset_ctl", {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_is_branch}, 32'd0);
    rst = 0;
    step(1);
    #1 chk("release_capture", 32'(ex_valid), 32'd1);

    // ADD x3 followed by ADD x4,x3,x3 with both MEM and WB producing x3
    set_alu(5'd3, 5'd1, 5'd2, 32'h5, 32'h6);
    step(1);
    set_alu(5'd4, 5'd3, 5'd3, 32'h0, 32'h0);
    step(1);
    idle_inputs();
    exmem_rd = 3; exmem_reg_write = 1; exmem_result = 32'h10;
    memwb_rd = 3; memwb_reg_write = 1; memwb_result = 32'h20;
    #1 chk("fwd_exmem_in1", ex_in1, 32'h10);
    chk("fwd_exmem_in2", ex_in2, 32'h10);
    step(1);

    // Load-use on x5
    idle_inputs();
    set_alu(5'd5, 5'd1, 5'd0, 32'h100, 32'h0);
    id_mem_read = 1; id_use_imm = 1; id_imm = 32'h4;
    step(1);
    set_alu(5'd6, 5'd5, 5'd2, 32'h0, 32'h7);
    #1 chk("load_use_hazard", 32'(hazard_stall), 32'd1);
    step(1);
    #1 chk("load_use_bubble", 32'(ex_valid), 32'd0);
    step(1);
    #1 chk("load_use_capture", 32'(ex_valid), 32'd1);
    idle_inputs();
    memwb_rd = 5; memwb_reg_write = 1; memwb_result = 32'hABCD;
    #1 chk("load_fwd_memwb", ex_in1, 32'hABCD);
    step(1);

    // Flush together with stall, then a stall lasting three cycles
    set_alu(5'd7, 5'd1, 5'd2, 32'h1, 32'h2);
    flush = 1; stall = 1;
    step(1);
    #1 chk("flush_stall_valid", 32'(ex_valid), 32'd0);
    chk("flush_stall_rw", 32'(ex_reg_write), 32'd0);
    flush = 0; stall = 0;
    step(1);
    set_alu(5'd9, 5'd8, 5'd8, 32'h3, 32'h4);
    stall = 1;
    for (int i = 0; i < 3; i++) step(1);
    #1 chk("stall_hold_rd", 32'(ex_rd), 32'd7);
    stall = 0;

    // x0 is never forwarded
    idle_inputs();
    set_alu(5'd1, 5'd0, 5'd2, 32'h0, 32'h9);
    step(1);
    exmem_rd = 0; exmem_reg_write = 1; exmem_result = 32'hDEAD;
    id_valid = 0;
    #1 chk("x0_no_fwd", ex_in1, 32'h0);
    step(1);

    // Immediate operand with a forwarded rs2 for the store data
    idle_inputs();
    set_alu(5'd0, 5'd1, 5'd7, 32'h1, 32'h11);
    id_use_imm = 1; id_imm = 32'hFFFF_FFF0; id_mem_write = 1; id_reg_write = 0;
    step(1);
    idle_inputs();
    exmem_rd = 7; exmem_reg_write = 1; exmem_result = 32'h77;
    #1 chk("imm_in2", ex_in2, 32'hFFFF_FFF0);
    chk("store_fwd", ex_store_data, 32'h77);
    step(1);

    // Randomized traffic on a small register set so hazards and forwards collide
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 7) == 0);
      id_valid = ($urandom_range(0, 7) != 0);
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom_range(0, 3));
      id_rs1_data = $urandom; id_rs2_data = $urandom;
      id_imm = $urandom; id_use_imm = 1'($urandom);
      id_alu_ctrl = 4'($urandom_range(0, 13)); id_pc = $urandom;
      id_reg_write = 1'($urandom); id_mem_read = ($urandom_range(0, 2) == 0);
      id_mem_write = ($urandom_range(0, 3) == 0); id_is_branch = ($urandom_range(0, 4) == 0);
      exmem_rd = 5'($urandom_range(0, 3)); exmem_reg_write = 1'($urandom);
      exmem_result = $urandom;
      memwb_rd = 5'($urandom_range(0, 3)); memwb_reg_write = 1'($urandom);
      memwb_result = $urandom;
      step(1);
    end

    idle_inputs();
    #1 check_all();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
